// File: rtl/ram_access_unit.sv
// ram_access_unit
//   Load/store initiator for a 32-bit word-organised RAM. Accepts one RV32I
//   load or store at a time over a valid/ready handshake. It drives the RAM
//   read/write pins and returns a single response beat carrying the extended
//   load data and an error flag. The RAM only writes whole words, so byte and
//   half stores read the word first, replace the selected lane(s) and then
//   write the whole word back.
//
// Ports
//   clk, rst_n                  clock and asynchronous active-low reset
//   req_valid/req_ready         request handshake; req_ready is high only in IDLE
//   req_we, req_funct3          store flag and RV32I access size/sign code
//   req_addr, req_wdata         byte address and right-aligned store data
//   resp_valid/resp_ready       response handshake; the response is held until consumed
//   resp_rdata, resp_err        extended load data (0 for stores/errors), error flag
//   ram_wen/ram_ren             RAM write/read enables, never high together
//   ram_waddr/ram_raddr         RAM word address (both carry the latched word index)
//   ram_wdata, ram_rdata        RAM write data (full word) and read data
module ram_access_unit #(
  parameter int ADDR_W       = 14,
  parameter int DEPTH        = 16000,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  // Value of the read-cycle counter in the cycle where ram_rdata is valid.
  localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                we_r, we_s;
  logic [2:0]          f3_r, f3_s;
  logic [1:0]          boff_r, boff_s;
  logic [ADDR_W-1:0]   widx_r, widx_s;
  logic [31:0]         wdata_r, wdata_s;
  logic [1:0]          cnt_r, cnt_s;
  logic                resp_valid_r, resp_valid_s;
  logic                resp_err_r, resp_err_s;
  logic [31:0]         resp_rdata_r, resp_rdata_s;
  logic                ram_wen_r, ram_wen_s;
  logic                ram_ren_r, ram_ren_s;
  logic [31:0]         ram_wdata_r, ram_wdata_s;
  logic                req_err_s;

  // Misaligned, out-of-range or illegal-funct3 request.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic misaligned;
    logic out_of_range;
    logic illegal;
    case (f3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = |addr[1:0];
      default:     misaligned = 1'b0;
    endcase
    out_of_range = (|addr[31:ADDR_W+2]) ||
                   ({{(32-ADDR_W){1'b0}}, addr[ADDR_W+1:2]} >= 32'(DEPTH));
    if (we) begin
      illegal = !(f3 inside {F3_B, F3_H, F3_W});
    end else begin
      illegal = f3 inside {3'b011, 3'b110, 3'b111};
    end
    return misaligned || out_of_range || illegal;
  endfunction

  // Select the addressed lane of a read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0] boff,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {boff, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'd0, sh[7:0]};
      F3_HU:   return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Replace the byte/half lane(s) of the old word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0] boff,
                                              input logic [2:0] f3);
    logic [31:0] mask;
    logic [31:0] data;
    case (f3)
      F3_B: begin
        mask = 32'h0000_00FF << {boff, 3'b000};
        data = {4{wdata[7:0]}};
      end
      F3_H: begin
        mask = 32'h0000_FFFF << {boff[1], 4'b0000};
        data = {2{wdata[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wdata;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

  assign req_err_s  = req_error(req_we, req_funct3, req_addr);
  assign req_ready  = rst_n & (state_r == ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign ram_wen    = ram_wen_r;
  assign ram_ren    = ram_ren_r;
  assign ram_waddr  = widx_r;
  assign ram_raddr  = widx_r;
  assign ram_wdata  = ram_wdata_r;

  // Next-state, request latching and next values of the registered outputs.
  always_comb begin
    state_s      = state_r;
    we_s         = we_r;
    f3_s         = f3_r;
    boff_s       = boff_r;
    widx_s       = widx_r;
    wdata_s      = wdata_r;
    cnt_s        = cnt_r;
    resp_err_s   = resp_err_r;
    resp_rdata_s = resp_rdata_r;
    ram_wdata_s  = ram_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          we_s         = req_we;
          f3_s         = req_funct3;
          boff_s       = req_addr[1:0];
          widx_s       = req_addr[ADDR_W+1:2];
          wdata_s      = req_wdata;
          cnt_s        = 2'd0;
          resp_err_s   = 1'b0;
          resp_rdata_s = 32'd0;
          if (req_err_s) begin
            state_s    = ST_RESP;
            resp_err_s = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_s     = ST_WRITE;
            ram_wdata_s = req_wdata;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_r == LAST_CNT) begin
          if (we_r) begin
            state_s     = ST_WRITE;
            ram_wdata_s = merge_store(ram_rdata, wdata_r, boff_r, f3_r);
          end else begin
            state_s      = ST_RESP;
            resp_rdata_s = load_extend(ram_rdata, boff_r, f3_r);
          end
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      ST_WRITE: begin
        state_s = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s      = ST_IDLE;
          resp_err_s   = 1'b0;
          resp_rdata_s = 32'd0;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Strobes are decoded from the next state so they are registered outputs.
    ram_ren_s    = (state_s == ST_READ);
    ram_wen_s    = (state_s == ST_WRITE);
    resp_valid_s = (state_s == ST_RESP);
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      f3_r         <= 3'd0;
      boff_r       <= 2'd0;
      widx_r       <= '0;
      wdata_r      <= 32'd0;
      cnt_r        <= 2'd0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      ram_wen_r    <= 1'b0;
      ram_ren_r    <= 1'b0;
      ram_wdata_r  <= 32'd0;
    end else begin
      state_r      <= state_s;
      we_r         <= we_s;
      f3_r         <= f3_s;
      boff_r       <= boff_s;
      widx_r       <= widx_s;
      wdata_r      <= wdata_s;
      cnt_r        <= cnt_s;
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
      ram_wen_r    <= ram_wen_s;
      ram_ren_r    <= ram_ren_s;
      ram_wdata_r  <= ram_wdata_s;
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// tb_ram_access_unit
//   Scoreboard bench for ram_access_unit. The stimulus side computes each
//   request's expected response, access counts and latency from a byte-level
//   memory model and queues them. A monitor observes the RAM pins and the
//   response handshake and checks each response against the queue head. A
//   word-RAM model answers reads only in the last cycle of a read pulse.
module tb_ram_access_unit;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16000;
  localparam int LAT    = 3;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              ram_wen;
  logic              ram_ren;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  ram_access_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        err;
    bit [31:0] rdata;
    int        ren;
    int        wen;
    bit [31:0] wword;
    int        lat;
    int        widx;
  } exp_t;

  exp_t      q[$];
  bit [31:0] ref_mem [int];
  int        n_cmp = 0;
  int        n_fail = 0;
  int        wen_total = 0;
  bit        hold_ready = 1'b0;

  // Word RAM model: data is valid only in the LAT-th cycle of a ren pulse.
  logic [31:0] mem [0:16383];
  int          ren_run = 0;
  bit   [31:0] noise = 32'd0;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ren_run <= ren_run + 1;
    else ren_run <= 0;
    noise <= $urandom();
  end
  always_comb begin
    if (ram_ren && ren_run == LAT - 1) ram_rdata = mem[ram_raddr];
    else ram_rdata = noise;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory semantics of RV32I loads/stores.
  function automatic exp_t model(input bit we, input bit [2:0] f3,
                                 input bit [31:0] addr, input bit [31:0] wd);
    exp_t e;
    int size;
    bit legal;
    int sh;
    bit [31:0] word, v, mask;
    e = '{default: 0};
    legal = 1'b1;
    size = 1;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    legal = 1'b0;
    endcase
    if (we && f3 > 3'd2) legal = 1'b0;
    if (!legal || (addr % 32'(size)) != 32'd0 || addr >= 32'(DEPTH * 4)) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    e.widx = int'(addr / 32'd4);
    word = ref_mem[e.widx];
    sh = int'(addr % 32'd4) * 8;
    if (!we) begin
      v = word >> sh;
      case (f3)
        3'd0:    e.rdata = (v & 32'hFF) | (v[7] ? 32'hFFFF_FF00 : 32'h0);
        3'd4:    e.rdata = v & 32'hFF;
        3'd1:    e.rdata = (v & 32'hFFFF) | (v[15] ? 32'hFFFF_0000 : 32'h0);
        3'd5:    e.rdata = v & 32'hFFFF;
        default: e.rdata = word;
      endcase
      e.ren = LAT;
      e.lat = LAT + 1;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1) << sh;
      e.wword = (word & ~mask) | ((wd << sh) & mask);
      ref_mem[e.widx] = e.wword;
      e.wen = 1;
      if (size == 4) begin
        e.lat = 2;
      end else begin
        e.ren = LAT;
        e.lat = LAT + 2;
      end
    end
    return e;
  endfunction

  // Present a request until accepted; called just after a rising edge.
  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd);
    int n;
    q.push_back(model(we, f3, addr, wd));
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got no req_ready expected accept within 100 cycles");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom();
    req_wdata = $urandom();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Response consumer: random back-pressure unless a test holds it off.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: per-transaction access counting, latency and response checks.
  initial begin : monitor
    bit in_txn;
    int cyc, ren_n, wen_n, resp_cyc;
    bit [31:0] wword;
    exp_t e;
    in_txn = 1'b0; cyc = 0; ren_n = 0; wen_n = 0; resp_cyc = -1; wword = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 1'b0;
      end else begin
        if (ram_ren && ram_wen) chk("ren_wen_exclusive", 32'(ram_ren & ram_wen), 32'd0);
        if (ram_wen) wen_total++;
        if (req_valid && req_ready) begin
          in_txn = 1'b1; cyc = 0; ren_n = 0; wen_n = 0; resp_cyc = -1; wword = 32'd0;
        end else if (in_txn) begin
          cyc++;
          if (ram_ren) begin
            ren_n++;
            if (q.size() > 0) chk("raddr", 32'(ram_raddr), 32'(q[0].widx));
          end
          if (ram_wen) begin
            wen_n++;
            wword = ram_wdata;
            if (q.size() > 0) chk("waddr", 32'(ram_waddr), 32'(q[0].widx));
          end
          if (resp_valid && resp_cyc < 0) resp_cyc = cyc;
          if (resp_valid && resp_ready) begin
            if (q.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL unexpected_resp: got response expected none");
            end else begin
              e = q.pop_front();
              chk("resp_err", 32'(resp_err), 32'(e.err));
              chk("resp_rdata", resp_rdata, e.rdata);
              chk("resp_latency", 32'(resp_cyc), 32'(e.lat));
              chk("ren_cycles", 32'(ren_n), 32'(e.ren));
              chk("wen_cycles", 32'(wen_n), 32'(e.wen));
              if (e.wen == 1) chk("write_word", wword, e.wword);
            end
            in_txn = 1'b0;
          end
        end else begin
          chk("idle_no_access", 32'(ram_ren | ram_wen), 32'd0);
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic and a reset abort.
  initial begin : stimulus
    bit [31:0] old_word;
    int n, wen_before, w, widx, r;
    bit [31:0] addr;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_strobes", 32'({ram_ren, ram_wen, resp_err}), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_addr", 32'({ram_waddr, ram_raddr}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // SW then LW at word 4
    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    drain();

    // Held response stays stable and blocks new requests
    hold_ready = 1'b1;
    issue(1'b0, 3'd2, 32'h10, $urandom());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 50);
    repeat (5) begin
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    hold_ready = 1'b0;
    drain();

    // Byte store read-modify-write and byte loads
    issue(1'b1, 3'd2, 32'h10, 32'h1122_3344);
    issue(1'b1, 3'd0, 32'h13, 32'h0000_00AA);
    issue(1'b0, 3'd4, 32'h13, 32'h0);
    issue(1'b0, 3'd0, 32'h13, 32'h0);
    // Half loads with sign/zero extension
    issue(1'b1, 3'd2, 32'h10, 32'h8001_7FFF);
    issue(1'b0, 3'd1, 32'h10, 32'h0);
    issue(1'b0, 3'd1, 32'h12, 32'h0);
    issue(1'b0, 3'd5, 32'h12, 32'h0);
    // Errors: misaligned word, misaligned half store, first out-of-range word
    issue(1'b0, 3'd2, 32'h11, 32'h0);
    issue(1'b1, 3'd1, 32'h13, 32'h0);
    issue(1'b0, 3'd2, 32'h0000_FA00, 32'h0);
    // Last legal word
    issue(1'b1, 3'd2, 32'(4 * (DEPTH - 1)), 32'h5A5A_0F0F);
    issue(1'b0, 3'd2, 32'(4 * (DEPTH - 1)), 32'h0);
    drain();

    // Initialize the random-traffic region: words 0..31 plus the last two
    for (int i = 0; i < 34; i++) begin
      widx = (i < 32) ? i : DEPTH - 34 + i;
      issue(1'b1, 3'd2, 32'(widx * 4), $urandom());
    end
    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        w = int'($urandom_range(0, 33));
        widx = (w < 32) ? w : DEPTH - 34 + w;
        addr = 32'(widx * 4) + 32'($urandom_range(0, 3));
      end else if (r == 7) begin
        addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      end else if (r == 8) begin
        addr = $urandom() | 32'h0001_0000;
      end else begin
        addr = $urandom();
      end
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    // Half store on word 8 then reset abort of a second one during READ
    issue(1'b1, 3'd2, 32'h20, 32'hCAFE_BABE);
    issue(1'b1, 3'd1, 32'h22, 32'h0000_1234);
    issue(1'b0, 3'd2, 32'h20, 32'h0);
    issue(1'b1, 3'd2, 32'h20, 32'hCAFE_BABE);
    drain();
    old_word = ref_mem[8];
    wen_before = wen_total;
    issue(1'b1, 3'd1, 32'h22, 32'h0000_5678);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ram_ren && n < 20);
    chk("abort_in_read", 32'(ram_ren), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({ram_ren, ram_wen, resp_valid, resp_err, req_ready}), 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_wdata", ram_wdata, 32'd0);
    q.delete();
    ref_mem[8] = old_word;
    repeat (3) @(negedge clk);
    chk("abort_no_write", 32'(wen_total), 32'(wen_before));
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 3'd2, 32'h20, 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
